// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_pkg
//  Description : Shared definitions for the systolic MAC array controllers.
//                Holds the one-hot controller state encodings and the width
//                helper used for row/column index buses.
//  Revision    : 1.0 - initial release
// ============================================================================
package systolic_pkg;

    // One-hot controller states, shared with the MAC controller.
    localparam logic [2:0] S_IDLE  = 3'b001;
    localparam logic [2:0] S_DRAIN = 3'b010;
    localparam logic [2:0] S_CLEAR = 3'b100;

    // Index width for a size x size grid; never narrower than one bit so a
    // 1x1 array still has a legal bus.
    function automatic int idx_w(input int size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_idx_counter.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_idx_counter
//  Description : Row-major (row, col) wrap counter over a SIZE x SIZE grid.
//                col advances on every inc; when col wraps, row advances.
//                last flags the final grid position (SIZE-1, SIZE-1).
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                clr           - synchronous return to (0,0)
//                inc           - advance one position
//                row, col      - current position
//                last          - position is (SIZE-1, SIZE-1)
//  Revision    : 1.0 - initial release
// ============================================================================
module systolic_idx_counter
    import systolic_pkg::*;
#(
    parameter int SIZE  = 4,
    parameter int IDX_W = idx_w(SIZE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [IDX_W-1:0] row,
    output logic [IDX_W-1:0] col,
    output logic             last
);

    localparam logic [IDX_W-1:0] c_MAX = IDX_W'(SIZE - 1);

    logic [IDX_W-1:0] r_row;
    logic [IDX_W-1:0] r_col;
    logic             w_col_wrap;
    logic             w_row_wrap;

    assign w_col_wrap = (r_col == c_MAX);
    assign w_row_wrap = (r_row == c_MAX);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_row <= '0;
            r_col <= '0;
        end else if (inc) begin
            if (w_col_wrap) begin
                r_col <= '0;
                // Wrapping row as well keeps the counter inside the grid even
                // if inc arrives at the last position.
                r_row <= w_row_wrap ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign row  = r_row;
    assign col  = r_col;
    assign last = w_col_wrap && w_row_wrap;

endmodule
`default_nettype wire

// File: rtl/systolic_drain_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_drain_ctrl
//  Description : Result-drain controller for the systolic MAC array. On start
//                it walks the SIZE x SIZE accumulator grid in row-major order,
//                streaming each result on a val/rdy interface, then pulses
//                acc_clr and done for one cycle and returns to idle.
//  Ports       : clk, rst   - clock, synchronous active-high reset
//                start      - drain request (sampled only in IDLE)
//                row_sel    - array row driving acc_data (0 outside DRAIN)
//                acc_data   - results of the selected row, column-indexed
//                send_msg   - current result word
//                send_val   - send_msg valid
//                send_rdy   - consumer ready
//                acc_clr    - one-cycle clear of all PE accumulators
//                busy       - controller not idle
//                done       - one-cycle completion strobe
//  Revision    : 1.0 - initial release
// ============================================================================
module systolic_drain_ctrl
    import systolic_pkg::*;
#(
    parameter int SIZE       = 4,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = idx_w(SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [IDX_W-1:0]      row_sel,
    input  logic [DATA_WIDTH-1:0] acc_data [SIZE],
    output logic [DATA_WIDTH-1:0] send_msg,
    output logic                  send_val,
    input  logic                  send_rdy,
    output logic                  acc_clr,
    output logic                  busy,
    output logic                  done
);

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [IDX_W-1:0] w_row;
    logic [IDX_W-1:0] w_col;
    logic             w_last;
    logic             w_xfer;
    logic             w_cnt_clr;

    assign w_xfer    = send_val && send_rdy;
    // Counters sit at (0,0) whenever no drain is in flight, so a fresh start
    // always begins at the first word.
    assign w_cnt_clr = (r_state != S_DRAIN);

    systolic_idx_counter #(
        .SIZE  (SIZE),
        .IDX_W (IDX_W)
    ) u_idx (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_cnt_clr),
        .inc  (w_xfer),
        .row  (w_row),
        .col  (w_col),
        .last (w_last)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_xfer && w_last) w_state_nxt = S_CLEAR;
            S_CLEAR: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        send_val = 1'b0;
        acc_clr  = 1'b0;
        done     = 1'b0;
        busy     = 1'b1;
        row_sel  = '0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_DRAIN: begin
                send_val = 1'b1;
                row_sel  = w_row;
            end
            S_CLEAR: begin
                acc_clr = 1'b1;
                done    = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Column mux; compare-based so a 1-wide grid needs no index truncation.
    always_comb begin
        send_msg = acc_data[0];
        for (int i = 1; i < SIZE; i++) begin
            if (w_col == IDX_W'(i)) begin
                send_msg = acc_data[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_drain_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_systolic_drain_ctrl
//  Description : Self-checking bench for systolic_drain_ctrl (SIZE=4 and
//                SIZE=1 instances). Vector table for the basic drain plus
//                hand-written sequences for stalls, back-to-back starts,
//                reset mid-drain and the 1x1 grid.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_drain_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        send_rdy;
    logic [1:0]  row_sel;
    logic [31:0] acc_data [4];
    logic [31:0] send_msg;
    logic        send_val;
    logic        acc_clr;
    logic        busy;
    logic        done;

    logic        start1;
    logic        rdy1;
    logic [0:0]  row_sel1;
    logic [31:0] acc1 [1];
    logic [31:0] msg1;
    logic        val1;
    logic        clr1;
    logic        busy1;
    logic        done1;

    int n_checks;
    int n_pass;

    systolic_drain_ctrl #(.SIZE(4), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .row_sel(row_sel),
        .acc_data(acc_data), .send_msg(send_msg), .send_val(send_val),
        .send_rdy(send_rdy), .acc_clr(acc_clr), .busy(busy), .done(done)
    );

    systolic_drain_ctrl #(.SIZE(1), .DATA_WIDTH(32)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .row_sel(row_sel1),
        .acc_data(acc1), .send_msg(msg1), .send_val(val1),
        .send_rdy(rdy1), .acc_clr(clr1), .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PE array model: row r, column c holds 16r+c.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            acc_data[c] = 32'(16 * int'(row_sel) + c);
        end
    end
    assign acc1[0] = 32'hDEADBEEF;

    typedef struct {
        logic        rst;
        logic        start;
        logic        rdy;
        logic        val;
        logic [31:0] msg;
        logic [1:0]  row;
        logic        clr;
        logic        dn;
        logic        bsy;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] word(input int k);
        return 32'(16 * (k / 4) + (k % 4));
    endfunction

    task automatic add(input logic r, input logic s, input logic rd,
                       input logic v, input logic [31:0] m, input logic [1:0] rw,
                       input logic c, input logic d, input logic b);
        vec_t e;
        e.rst = r; e.start = s; e.rdy = rd; e.val = v; e.msg = m;
        e.row = rw; e.clr = c; e.dn = d; e.bsy = b;
        vecs.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int dones;
        int cyc;
        logic stalled;
        logic [31:0] held;
        logic r;
        logic [3:0] pat;

        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1; start = 1'b0; send_rdy = 1'b0;
        start1 = 1'b0; rdy1 = 1'b1;

        // ---------------- vector table: reset, idle, full drain -----------
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 1, word(0), 0, 0, 0, 1);
        for (int i = 1; i < 16; i++) add(0, 0, 1, 1, word(i), 2'(i / 4), 0, 0, 1);
        add(0, 0, 1, 0, 0, 0, 1, 1, 1);
        add(0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; start = vecs[i].start; send_rdy = vecs[i].rdy;
            tick();
            chk($sformatf("vec%0d send_val", i), 32'(send_val), 32'(vecs[i].val));
            chk($sformatf("vec%0d acc_clr", i), 32'(acc_clr), 32'(vecs[i].clr));
            chk($sformatf("vec%0d done", i), 32'(done), 32'(vecs[i].dn));
            chk($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].bsy));
            chk($sformatf("vec%0d row_sel", i), 32'(row_sel), 32'(vecs[i].row));
            if (vecs[i].val) chk($sformatf("vec%0d send_msg", i), send_msg, vecs[i].msg);
        end

        // ---------------- stalls: random send_rdy --------------------------
        pat = 4'b1001; // cycle 0..3 -> 1,0,0,1
        start = 1'b1; send_rdy = 1'b0;
        tick();
        start = 1'b0;
        k = 0; dones = 0; stalled = 1'b0; held = '0;
        for (cyc = 0; cyc < 300; cyc++) begin
            if (k == 16 && !busy) break;
            if (stalled) begin
                chk("stall val held", 32'(send_val), 32'd1);
                chk("stall msg held", send_msg, held);
            end
            if (done) dones++;
            r = (cyc < 4) ? pat[3 - cyc] : 1'($urandom_range(0, 1));
            send_rdy = r;
            if (send_val && r) begin
                chk($sformatf("stall word%0d", k), send_msg, word(k));
                k++;
            end
            stalled = send_val && !r;
            held = send_msg;
            tick();
        end
        chk("stall transfer count", 32'(k), 32'd16);
        chk("stall done count", 32'(dones), 32'd1);
        chk("stall ends idle", 32'(busy), 32'd0);

        // ---------------- start held high: back-to-back drains -------------
        start = 1'b1; send_rdy = 1'b1;
        for (int t = 1; t <= 19; t++) begin
            tick();
            if (t <= 16) chk($sformatf("b2b word%0d", t - 1), send_msg, word(t - 1));
            if (t <= 16) chk($sformatf("b2b val t%0d", t), 32'(send_val), 32'd1);
            if (t == 17) chk("b2b clear done", 32'(done), 32'd1);
            if (t == 17) chk("b2b clear acc_clr", 32'(acc_clr), 32'd1);
            if (t == 18) chk("b2b idle gap busy", 32'(busy), 32'd0);
            if (t == 19) chk("b2b restart val", 32'(send_val), 32'd1);
            if (t == 19) chk("b2b restart word0", send_msg, word(0));
        end
        start = 1'b0;
        for (cyc = 0; cyc < 40 && busy; cyc++) tick();
        chk("b2b second drain completes", 32'(busy), 32'd0);

        // ---------------- reset after the 7th transfer ---------------------
        start = 1'b1; send_rdy = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t < 7; t++) tick();
        chk("pre-reset word7", send_msg, word(7));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst mid send_val", 32'(send_val), 32'd0);
        chk("rst mid acc_clr", 32'(acc_clr), 32'd0);
        chk("rst mid done", 32'(done), 32'd0);
        chk("rst mid busy", 32'(busy), 32'd0);
        tick();
        chk("post-rst no clr", 32'(acc_clr | done), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart val", 32'(send_val), 32'd1);
        chk("restart word0", send_msg, word(0));
        chk("restart row0", 32'(row_sel), 32'd0);
        for (cyc = 0; cyc < 40 && busy; cyc++) tick();

        // ---------------- start together with rst --------------------------
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        chk("rst+start busy", 32'(busy), 32'd0);
        chk("rst+start val", 32'(send_val), 32'd0);

        // ---------------- 1x1 grid -----------------------------------------
        rdy1 = 1'b1; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("s1 val", 32'(val1), 32'd1);
        chk("s1 msg", msg1, 32'hDEADBEEF);
        chk("s1 row_sel", 32'(row_sel1), 32'd0);
        tick();
        chk("s1 val after xfer", 32'(val1), 32'd0);
        chk("s1 acc_clr", 32'(clr1), 32'd1);
        chk("s1 done", 32'(done1), 32'd1);
        tick();
        chk("s1 clr single", 32'(clr1 | done1), 32'd0);
        chk("s1 idle", 32'(busy1), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
